apb_uart16550_requester: RTL and testbench
==========================================

Name: apb_uart16550_requester

Overview:
APB4 initiator (master) that turns a simple valid/ready command stream into APB4 transfers. It is used to drive apb_uart16550 register accesses from a local controller, such as a boot sequencer, a debug bridge or a test harness. It runs a single-outstanding SETUP/ACCESS state machine with wait-state support, PSLVERR capture, an optional ACCESS timeout, and a back-pressured response channel.

Parameters:
ADDR_WIDTH, 3, width of PADDR/req_addr_i (UART16550 register map is 8 locations)
DATA_WIDTH, 8, width of PWDATA/PRDATA; must be a multiple of 8
TIMEOUT, 16, maximum ACCESS cycles with PREADY low before abort; 0 disables the timeout

Ports:
PCLK  in  1  clock, rising edge
PRESETn  in  1  asynchronous active-low reset
req_valid_i  in  1  command valid
req_ready_o  out  1  command accepted when req_valid_i & req_ready_o
req_write_i  in  1  1=write, 0=read
req_addr_i  in  ADDR_WIDTH  register address
req_wdata_i  in  DATA_WIDTH  write data
req_prot_i  in  3  protection attributes, forwarded to PPROT
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed when rsp_valid_o & rsp_ready_i
rsp_rdata_o  out  DATA_WIDTH  read data; 0 for writes and aborted transfers
rsp_err_o  out  1  PSLVERR sampled, or timeout
rsp_timeout_o  out  1  transfer aborted by timeout
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PADDR  out  ADDR_WIDTH  APB address
PWRITE  out  1  APB direction
PWDATA  out  DATA_WIDTH  APB write data
PSTRB  out  DATA_WIDTH/8  all ones for writes, all zeros for reads
PPROT  out  3  APB protection
PRDATA  in  DATA_WIDTH  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB error

Behaviour:
- Single clock PCLK; asynchronous active-low reset PRESETn.
- Reset values:
  - All outputs 0, except req_ready_o, which is 1 once out of reset.
  - State IDLE; timeout counter 0.
- States:
  - IDLE: req_ready_o=1; PSEL=0, PENABLE=0. On request handshake, latch write/addr/wdata/prot into PADDR/PWRITE/PWDATA/PSTRB/PPROT registers and go to SETUP.
  - SETUP (1 cycle): PSEL=1, PENABLE=0; go to ACCESS.
  - ACCESS: PSEL=1, PENABLE=1.
    - PREADY=1: sample PSLVERR into rsp_err_o. Sample PRDATA into rsp_rdata_o for reads; rsp_rdata_o=0 for writes. Go to RESP.
    - PREADY=0: increment the counter. When TIMEOUT!=0 and the counter reaches TIMEOUT, abort: rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0, go to RESP.
  - RESP: PSEL=0, PENABLE=0; rsp_valid_o=1, response fields held stable. On rsp_ready_i=1, go to IDLE and clear the counter.
- Control outputs (PSEL, PENABLE, req_ready_o, rsp_valid_o) are registered or decoded from state only. There is no combinational path from req_valid_i/PREADY to any output.
- PADDR/PWRITE/PWDATA/PSTRB/PPROT:
  - Stable from SETUP through the end of ACCESS.
  - Hold their last value in RESP/IDLE; they change only on a request handshake.
- Latency with zero wait states and rsp_ready_i=1:
  - Handshake at edge 0; SETUP cycle 1; ACCESS cycle 2; rsp_valid_o in cycle 3; req_ready_o again in cycle 4.
  - Throughput: one transfer per 4 cycles, plus 1 cycle per wait state.
- Exactly one transfer is outstanding; req_ready_o=0 in SETUP/ACCESS/RESP.
- PSLVERR is ignored unless PREADY=1 in ACCESS.
- Timeout boundary: a PREADY=1 arriving in the same cycle the counter reaches TIMEOUT completes normally; the timeout is not flagged.
- A timeout abort drops PSEL/PENABLE without PREADY. This is a deliberate recovery deviation from APB4.
- Asserting PRESETn=0 mid-transfer immediately (asynchronously) forces PSEL=0, PENABLE=0 and rsp_valid_o=0, and discards any pending response. The first post-reset state is IDLE.

Test Plan:
- Write LCR: req write addr=3 wdata=0x83, PREADY tied 1. Required: SETUP on cycle 1 (PSEL=1, PENABLE=0, PADDR=3, PWDATA=0x83, PSTRB=1); ACCESS on cycle 2; rsp_valid_o=1 on cycle 3 with err=0 and rdata=0x00.
- Read LSR with wait states: addr=5, PREADY low for 3 ACCESS cycles then high with PRDATA=0x60. Required: ACCESS lasts 4 cycles; PADDR stable throughout; PSTRB=0; rsp_rdata_o=0x60.
- Slave error: PSLVERR=1 together with PREADY=1. Required: rsp_err_o=1, rsp_timeout_o=0.
- Timeout with TIMEOUT=4 and PREADY stuck 0. Required: PSEL drops after 4 ACCESS cycles; rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0. Repeat with PREADY=1 on the 4th cycle: normal completion, timeout not flagged.
- Response back-pressure: rsp_ready_i held low 5 cycles. Required: rsp_valid_o and the response fields stay stable; req_ready_o=0; a second req_valid_i is not accepted until the cycle after rsp_ready_i=1.
- Reset mid-ACCESS: drop PRESETn while PSEL=1. Required: PSEL/PENABLE go 0 without waiting for a clock edge; after release, req_ready_o=1 and no response is emitted.

Source files
------------

// File: rtl/apb_uart16550_requester.sv
// APB4 requester: converts a valid/ready command stream into single-outstanding APB4 transfers.
// Latency: 4 cycles from handshake back to ready (plus wait states); the response is held until rsp_ready_i.
module apb_uart16550_requester #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_write_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [2:0]              req_prot_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    rsp_timeout_o,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic                    PWRITE,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [2:0]              PPROT,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int SW = DATA_WIDTH / 8;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic                    pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic [SW-1:0]           pstrb_q, pstrb_d;
  logic [2:0]              pprot_q, pprot_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic                    tmo_q, tmo_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    pprot_d  = pprot_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    tmo_d    = tmo_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          paddr_d  = req_addr_i;
          pwrite_d = req_write_i;
          pwdata_d = req_wdata_i;
          pstrb_d  = {SW{req_write_i}};
          pprot_d  = req_prot_i;
          state_d  = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        // PREADY wins over a timeout reached in the same cycle.
        if (PREADY) begin
          err_d   = PSLVERR;
          tmo_d   = 1'b0;
          rdata_d = pwrite_q ? '0 : PRDATA;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if ((TIMEOUT != 0) && (cnt_d == CW'(TIMEOUT))) begin
            err_d   = 1'b1;
            tmo_d   = 1'b1;
            rdata_d = '0;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      pprot_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      pstrb_q  <= pstrb_d;
      pprot_q  <= pprot_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
    end
  end

  // Control outputs decode state only, so reset drops them asynchronously.
  assign req_ready_o   = (state_q == IDLE);
  assign PSEL          = (state_q == SETUP) || (state_q == ACCESS);
  assign PENABLE       = (state_q == ACCESS);
  assign rsp_valid_o   = (state_q == RESP);
  assign rsp_rdata_o   = rdata_q;
  assign rsp_err_o     = err_q;
  assign rsp_timeout_o = tmo_q;
  assign PADDR         = paddr_q;
  assign PWRITE        = pwrite_q;
  assign PWDATA        = pwdata_q;
  assign PSTRB         = pstrb_q;
  assign PPROT         = pprot_q;

endmodule

// File: tb/tb_apb_uart16550_requester.sv
// Directed bench for apb_uart16550_requester (TIMEOUT=4); inputs driven and outputs sampled 1ns after each rising edge.
module tb_apb_uart16550_requester;

  logic       PCLK = 1'b0;
  logic       PRESETn;
  logic       req_valid_i, req_ready_o, req_write_i;
  logic [2:0] req_addr_i;
  logic [7:0] req_wdata_i;
  logic [2:0] req_prot_i;
  logic       rsp_valid_o, rsp_ready_i;
  logic [7:0] rsp_rdata_o;
  logic       rsp_err_o, rsp_timeout_o;
  logic       PSEL, PENABLE, PWRITE;
  logic [2:0] PADDR;
  logic [7:0] PWDATA;
  logic [0:0] PSTRB;
  logic [2:0] PPROT;
  logic [7:0] PRDATA;
  logic       PREADY, PSLVERR;

  int checks = 0;
  int failures = 0;

  apb_uart16550_requester #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .TIMEOUT(4)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_prot_i(req_prot_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PSTRB(PSTRB), .PPROT(PPROT), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic request(input logic wr, input logic [2:0] addr, input logic [7:0] wd, input logic [2:0] prot);
    req_valid_i = 1'b1;
    req_write_i = wr;
    req_addr_i  = addr;
    req_wdata_i = wd;
    req_prot_i  = prot;
  endtask

  initial begin
    PRESETn = 1'b0;
    req_valid_i = 0; req_write_i = 0; req_addr_i = 0; req_wdata_i = 0; req_prot_i = 0;
    rsp_ready_i = 0; PRDATA = 0; PREADY = 0; PSLVERR = 0;
    #12;
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_rsp_err", rsp_err_o, 0);
    chk("rst_rsp_timeout", rsp_timeout_o, 0);
    chk("rst_rdata", rsp_rdata_o, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pstrb", PSTRB, 0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    step();
    chk("idle_ready", req_ready_o, 1);

    // Write LCR, zero wait states
    PREADY = 1; rsp_ready_i = 1;
    request(1'b1, 3'd3, 8'h83, 3'd0);
    step();
    req_valid_i = 0;
    chk("wr_setup_psel", PSEL, 1);
    chk("wr_setup_penable", PENABLE, 0);
    chk("wr_setup_paddr", PADDR, 3);
    chk("wr_setup_pwdata", PWDATA, 8'h83);
    chk("wr_setup_pstrb", PSTRB, 1);
    chk("wr_setup_pwrite", PWRITE, 1);
    chk("wr_setup_ready", req_ready_o, 0);
    step();
    chk("wr_access_psel", PSEL, 1);
    chk("wr_access_penable", PENABLE, 1);
    step();
    chk("wr_resp_valid", rsp_valid_o, 1);
    chk("wr_resp_err", rsp_err_o, 0);
    chk("wr_resp_rdata", rsp_rdata_o, 0);
    chk("wr_resp_psel", PSEL, 0);
    step();
    chk("wr_back_ready", req_ready_o, 1);
    chk("wr_back_valid", rsp_valid_o, 0);

    // Read LSR with 3 wait states; PSLVERR toggled while PREADY low must be ignored
    PREADY = 0; PRDATA = 8'h60; PSLVERR = 1;
    request(1'b0, 3'd5, 8'hFF, 3'd2);
    step();
    req_valid_i = 0;
    chk("rd_setup_pstrb", PSTRB, 0);
    chk("rd_setup_pwrite", PWRITE, 0);
    chk("rd_setup_pprot", PPROT, 2);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("rd_access%0d_penable", i), PENABLE, 1);
      chk($sformatf("rd_access%0d_paddr", i), PADDR, 5);
      if (i == 4) begin
        PREADY = 1; PSLVERR = 0;
      end
    end
    step();
    chk("rd_resp_valid", rsp_valid_o, 1);
    chk("rd_resp_rdata", rsp_rdata_o, 8'h60);
    chk("rd_resp_err", rsp_err_o, 0);
    step();

    // Slave error
    PSLVERR = 1;
    request(1'b1, 3'd1, 8'h5A, 3'd0);
    step();
    req_valid_i = 0;
    step();
    step();
    chk("err_resp_valid", rsp_valid_o, 1);
    chk("err_resp_err", rsp_err_o, 1);
    chk("err_resp_timeout", rsp_timeout_o, 0);
    chk("err_resp_rdata", rsp_rdata_o, 0);
    step();
    PSLVERR = 0;

    // Timeout: PREADY stuck low for 4 ACCESS cycles
    PREADY = 0;
    request(1'b0, 3'd2, 8'h00, 3'd0);
    step();
    req_valid_i = 0;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("to_access%0d_psel", i), PSEL, 1);
      chk($sformatf("to_access%0d_penable", i), PENABLE, 1);
    end
    step();
    chk("to_resp_psel", PSEL, 0);
    chk("to_resp_valid", rsp_valid_o, 1);
    chk("to_resp_err", rsp_err_o, 1);
    chk("to_resp_timeout", rsp_timeout_o, 1);
    chk("to_resp_rdata", rsp_rdata_o, 0);
    step();

    // Timeout boundary: PREADY arrives on the 4th ACCESS cycle
    PRDATA = 8'hA5;
    request(1'b0, 3'd2, 8'h00, 3'd0);
    step();
    req_valid_i = 0;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("tb_access%0d_penable", i), PENABLE, 1);
      if (i == 4) PREADY = 1;
    end
    step();
    chk("tb_resp_valid", rsp_valid_o, 1);
    chk("tb_resp_err", rsp_err_o, 0);
    chk("tb_resp_timeout", rsp_timeout_o, 0);
    chk("tb_resp_rdata", rsp_rdata_o, 8'hA5);
    step();

    // Response back-pressure with a second request waiting
    rsp_ready_i = 0; PRDATA = 8'h3C;
    request(1'b0, 3'd6, 8'h00, 3'd0);
    step();
    req_valid_i = 0;
    step();
    step();
    request(1'b1, 3'd7, 8'h11, 3'd1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d_valid", i), rsp_valid_o, 1);
      chk($sformatf("bp%0d_rdata", i), rsp_rdata_o, 8'h3C);
      chk($sformatf("bp%0d_ready", i), req_ready_o, 0);
      chk($sformatf("bp%0d_paddr", i), PADDR, 6);
      step();
    end
    rsp_ready_i = 1;
    chk("bp_last_valid", rsp_valid_o, 1);
    step();
    chk("bp_idle_ready", req_ready_o, 1);
    chk("bp_idle_valid", rsp_valid_o, 0);
    chk("bp_idle_paddr", PADDR, 6);
    step();
    req_valid_i = 0;
    chk("bp2_setup_psel", PSEL, 1);
    chk("bp2_setup_paddr", PADDR, 7);
    chk("bp2_setup_pwdata", PWDATA, 8'h11);
    step();
    step();
    chk("bp2_resp_valid", rsp_valid_o, 1);
    chk("bp2_resp_rdata", rsp_rdata_o, 0);
    step();

    // Asynchronous reset during ACCESS
    PREADY = 0;
    request(1'b0, 3'd4, 8'h00, 3'd0);
    step();
    req_valid_i = 0;
    step();
    chk("ar_pre_penable", PENABLE, 1);
    #1 PRESETn = 1'b0;
    #1;
    chk("ar_psel", PSEL, 0);
    chk("ar_penable", PENABLE, 0);
    chk("ar_rsp_valid", rsp_valid_o, 0);
    PREADY = 1;
    @(negedge PCLK);
    PRESETn = 1'b1;
    step();
    chk("ar_post_ready", req_ready_o, 1);
    chk("ar_post_psel", PSEL, 0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ar_post%0d_valid", i), rsp_valid_o, 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
